// File: rtl/key_pkg.sv
// Shared definitions for the key scanner / debouncer.
//
// Holds the FSM state encoding, the key bus width and the default timing
// constants used as parameter defaults by key_scan_debounce.
// Optional feature macro used by this slice: KEY_REPEAT_EN (auto-repeat).
package key_pkg;

    localparam int KEY_W               = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 2000000;   // 20 ms at 100 MHz
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms at 100 MHz
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms at 100 MHz

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } key_state_t;

    // Largest of three values; sizes the shared counters.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterised-width two-flop synchronizer.
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset; loads RST_LEVEL into both stages
//   async_lvl - asynchronous input levels
//   sync_lvl  - levels synchronised to clk (two-cycle delay)
module key_sync #(
    parameter int   WIDTH     = 4,
    parameter logic RST_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_lvl,
    output logic [WIDTH-1:0] sync_lvl
);

    logic [WIDTH-1:0] meta;

    // NOTE: flops are reset to the released key level, not to zero, so that
    // leaving reset never looks like every key being pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= {WIDTH{RST_LEVEL}};
            sync_lvl <= {WIDTH{RST_LEVEL}};
        end else begin
            meta     <= async_lvl;
            sync_lvl <= meta;
        end
    end

endmodule

// File: rtl/key_scan_debounce.sv
// Four-key scanner with press/release debounce and optional auto-repeat.
//
// A settled press pattern is reported once as a one-cycle key_flag pulse with
// key_value holding the active-high pattern until the next flag. Multi-key
// patterns are reported verbatim.
//
// Ports:
//   clk       - system clock (100 MHz)
//   rst       - synchronous active-high reset
//   key_in    - raw asynchronous push-button levels
//   key_flag  - single-cycle accepted-key pulse
//   key_value - pressed-key pattern, valid with key_flag and held afterwards
//
// Macro KEY_REPEAT_EN: when defined, a held key re-flags after REPEAT_DELAY
// cycles in PRESSED and then every REPEAT_PERIOD cycles (REPEAT_PERIOD >= 2
// keeps flags from touching). When undefined there is one flag per press.
module key_scan_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_flag,
    output logic [KEY_W-1:0] key_value
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] sync_lvl;
    logic [KEY_W-1:0] key_s;
    logic [KEY_W-1:0] cand;
    logic [CNT_W-1:0] cnt;
    key_state_t       state, next_state;
    logic             accept, cnt_clr, cnt_inc, cand_load, flag_set;

    key_sync #(
        .WIDTH    (KEY_W),
        .RST_LEVEL(KEY_ACTIVE_LOW != 0)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_lvl(key_in),
        .sync_lvl (sync_lvl)
    );

    assign key_s = (KEY_ACTIVE_LOW != 0) ? ~sync_lvl : sync_lvl;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cand_load  = 1'b0;
        case (state)
            IDLE: begin
                if (key_s != '0) begin
                    next_state = PRESS_DB;
                    cand_load  = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            PRESS_DB: begin
                if (key_s != cand) begin
                    next_state = IDLE;              // bounce: drop silently
                end else if (cnt == DB_LAST) begin
                    next_state = PRESSED;
                    accept     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            PRESSED: begin
                if (key_s != cand) begin
                    next_state = REL_DB;
                    cnt_clr    = 1'b1;
                end
            end
            REL_DB: begin
                if (key_s == cand) begin
                    next_state = PRESSED;           // release glitch, no new flag
                end else if (cnt == DB_LAST) begin
                    next_state = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_first;  // waiting for the initial, longer delay
    logic             rpt_fire;

    // Only fire while staying in PRESSED; a release in the same cycle wins.
    assign rpt_fire = (state == PRESSED) && (next_state == PRESSED) &&
                      (rpt_cnt == (rpt_first ? RD_LAST : RP_LAST));

    // Held clear outside PRESSED, so each entry starts a fresh delay.
    always_ff @(posedge clk) begin
        if (rst || state != PRESSED) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_cnt != '1) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign flag_set = accept | rpt_fire;
`else
    assign flag_set = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cand      <= '0;
            key_flag  <= 1'b0;
            key_value <= '0;
        end else begin
            key_flag <= flag_set;
            if (flag_set)  key_value <= cand;
            if (cand_load) cand      <= key_s;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc && cnt != '1)   // saturate, never wrap
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed self-checking bench for key_scan_debounce (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5, active-low keys). Build with
// KEY_REPEAT_EN defined to exercise auto-repeat instead of single-flag hold.
module tb_key_scan_debounce;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic       key_flag;
    logic [3:0] key_value;

    int tests_run    = 0;
    int tests_failed = 0;

    int         cyc = 0;
    int         flag_cyc[$];
    logic [3:0] flag_val[$];
    int         consec = 0;
    logic       prev_flag = 1'b0;

    key_scan_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_flag (key_flag),
        .key_value(key_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Flag monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (key_flag === 1'b1) begin
            flag_cyc.push_back(cyc);
            flag_val.push_back(key_value);
            if (prev_flag) consec++;
        end
        prev_flag = (key_flag === 1'b1);
    end

    task automatic clear_log();
        flag_cyc.delete();
        flag_val.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst    = 1'b1;
        key_in = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (key_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flag: got %b expected 0", key_flag);
        end
        tests_run++;
        if (key_value !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_value: got %b expected 0000", key_value);
        end
        rst = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        expect_int("idle_no_flag", flag_cyc.size(), 0);
    endtask

    task automatic test_key_sync();
        int t0;
        reset_dut();
        @(negedge clk);
        key_in = 4'hE;
        t0     = cyc;
        repeat (20) @(negedge clk);
        expect_int("key_sync_count", flag_cyc.size(), 1);
        if (flag_cyc.size() > 0) begin
            expect_int("key_sync_latency", flag_cyc[0] - t0, DB + 3);
            expect_int("key_sync_value", int'(flag_val[0]), 1);
        end
        key_in = 4'hF;
        repeat (15) @(negedge clk);
        expect_int("key_sync_release_no_flag", flag_cyc.size(), 1);
        expect_int("key_sync_value_held", int'(key_value), 1);
    endtask

    task automatic test_bounce();
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key_in = 4'hE;
            repeat (2) @(negedge clk);
            key_in = 4'hF;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        expect_int("bounce_count", flag_cyc.size(), 0);
        expect_int("bounce_value", int'(key_value), 0);
    endtask

    task automatic test_release_glitch();
        int t0;
        reset_dut();
        @(negedge clk);
        key_in = 4'hD;
        t0     = cyc;
        repeat (20) @(negedge clk);
        key_in = 4'hF;
        repeat (2) @(negedge clk);
        key_in = 4'hD;
        repeat (20) @(negedge clk);
        key_in = 4'hF;
        repeat (15) @(negedge clk);
        expect_int("glitch_count", flag_cyc.size(), 1);
        if (flag_cyc.size() > 0) begin
            expect_int("glitch_latency", flag_cyc[0] - t0, DB + 3);
            expect_int("glitch_value", int'(flag_val[0]), 2);
        end
    endtask

    task automatic test_reset_mid();
        int t1;
        reset_dut();
        @(negedge clk);
        key_in = 4'h7;
        repeat (4) @(negedge clk);       // now inside PRESS_DB
        rst = 1'b1;
        repeat (3) @(negedge clk);
        expect_int("rst_mid_no_flag", flag_cyc.size(), 0);
        rst = 1'b0;
        t1  = cyc;
        repeat (20) @(negedge clk);
        expect_int("rst_mid_count", flag_cyc.size(), 1);
        if (flag_cyc.size() > 0) begin
            expect_int("rst_mid_latency", flag_cyc[0] - t1, DB + 3);
            expect_int("rst_mid_value", int'(flag_val[0]), 8);
        end
        key_in = 4'hF;
        repeat (15) @(negedge clk);
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int t0;
        int exp_off[6];
        exp_off = '{0, RD, RD + RP, RD + 2*RP, RD + 3*RP, RD + 4*RP};
        reset_dut();
        @(negedge clk);
        key_in = 4'hB;
        t0     = cyc;
        repeat (40) @(negedge clk);
        expect_int("repeat_count", flag_cyc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < flag_cyc.size()) begin
                expect_int($sformatf("repeat_time_%0d", i), flag_cyc[i] - t0, DB + 3 + exp_off[i]);
                expect_int($sformatf("repeat_value_%0d", i), int'(flag_val[i]), 4);
            end
        end
        key_in = 4'hF;
        repeat (15) @(negedge clk);
    endtask
`else
    task automatic test_no_repeat();
        int t0;
        reset_dut();
        @(negedge clk);
        key_in = 4'hB;
        t0     = cyc;
        repeat (1000) @(negedge clk);
        expect_int("hold_count", flag_cyc.size(), 1);
        if (flag_cyc.size() > 0) begin
            expect_int("hold_latency", flag_cyc[0] - t0, DB + 3);
            expect_int("hold_value", int'(flag_val[0]), 4);
        end
        key_in = 4'hF;
        repeat (15) @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_key_sync();
        test_bounce();
        test_release_glitch();
        test_reset_mid();
`ifdef KEY_REPEAT_EN
        test_repeat();
`else
        test_no_repeat();
`endif
        expect_int("no_back_to_back_flags", consec, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/key_scan_debounce.md
KEY_SCAN_DEBOUNCE -- requirements
Module: key_scan_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 2000000, meaning stable-level cycles required to accept a press or release (20 ms at 100 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, meaning held cycles before the first auto-repeat flag.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10000000, meaning cycles between subsequent auto-repeat flags.
REQ-004 The block SHALL have parameter KEY_ACTIVE_LOW, default 1, meaning raw key level 0 is pressed when set.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port key_in, input, 4 bits: raw asynchronous push-button levels.
REQ-008 The block SHALL have port key_flag, output, 1 bit: single-cycle pulse marking an accepted key event.
REQ-009 The block SHALL have port key_value, output, 4 bits: pressed-key pattern, active-high, valid while key_flag is high and held until the next key_flag.

Function
REQ-010 Each key_in bit SHALL pass through a 2-flop synchronizer and be normalised to active-high key_s (pressed=1).
REQ-011 The FSM SHALL have exactly the states IDLE, PRESS_DB, PRESSED and REL_DB.
REQ-012 IDLE: key_s==0 SHALL hold IDLE; key_s!=0 SHALL latch cand<=key_s, clear cnt and go to PRESS_DB.
REQ-013 PRESS_DB: key_s!=cand SHALL return to IDLE without any flag (bounce); key_s==cand for DEBOUNCE_CYCLES consecutive cycles (cnt 0..DEBOUNCE_CYCLES-1) SHALL go to PRESSED.
REQ-014 On the PRESS_DB->PRESSED transition, key_flag SHALL be 1 for exactly one cycle and key_value SHALL be cand, registered in that same cycle.
REQ-015 PRESSED: key_s!=cand SHALL clear cnt and go to REL_DB; otherwise PRESSED SHALL hold.
REQ-016 REL_DB: key_s==cand SHALL return to PRESSED with no new flag; key_s!=cand for DEBOUNCE_CYCLES consecutive cycles SHALL go to IDLE.
REQ-017 A different key pressed while in PRESSED SHALL be reported only after a full release debounce, IDLE, and a fresh press debounce.
REQ-018 Multi-key patterns (e.g. 4'b0011) SHALL be reported verbatim in key_value; filtering is the consumer's job.
REQ-019 Total latency from a settled raw edge to key_flag SHALL be DEBOUNCE_CYCLES+3 clk cycles (2 sync, 1 IDLE exit, DEBOUNCE_CYCLES count).
REQ-020 Counters SHALL be $clog2 of the largest parameter plus 1 bits wide and SHALL saturate, never wrap.
REQ-021 key_flag SHALL never be high on two consecutive cycles.

Reset
REQ-022 rst SHALL set state=IDLE, cnt=0, cand=0, key_flag=0 and key_value=4'b0000 on the next clk edge.
REQ-023 rst SHALL set the synchronizer flops to the released level (all 1s when KEY_ACTIVE_LOW=1).
REQ-024 rst asserted mid-debounce or mid-hold SHALL abort the operation with no flag, and a still-held key SHALL be re-debounced as a new press after rst deasserts.

Configuration
REQ-025 With macro KEY_REPEAT_EN defined, PRESSED SHALL run a repeat counter, cleared on every entry to PRESSED.
REQ-026 With KEY_REPEAT_EN defined, the block SHALL pulse key_flag with key_value=cand after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles until PRESSED is left.
REQ-027 Without KEY_REPEAT_EN, the repeat counter SHALL be absent and exactly one key_flag SHALL occur per debounced press.

Structure
REQ-028 Shared package key_pkg SHALL hold the FSM state enum, default DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD constants, and KEY_W=4.
REQ-029 The design SHALL have one sub-module, key_sync: a parameterised-width 2-flop synchronizer with configurable reset level.

Verification
REQ-030 Test key_sync: DEBOUNCE_CYCLES=4; key_in 4'hF->4'hE held 20 cycles -> one key_flag 7 cycles after the edge, key_value=4'b0001.
REQ-031 Test bounce: key_in 4'hE for 2 cycles, then 4'hF, repeated 5 times, then 4'hF -> no key_flag; key_value stays 0.
REQ-032 Test release glitch: 4'hD held, released 2 cycles, re-pressed, held -> exactly one key_flag with key_value=4'b0010.
REQ-033 Test reset mid-operation: rst pulse mid-PRESS_DB while 4'h7 held -> no flag during rst; flag with 4'b1000 DEBOUNCE_CYCLES+3 cycles after rst deasserts.
REQ-034 Test repeat: KEY_REPEAT_EN defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, 4'hB held 40 cycles -> flags at press, +10, +15, +20, ..., all 4'b0100.
REQ-035 Test without KEY_REPEAT_EN: 4'hB held 1000 cycles -> exactly one key_flag.
